// File: rtl/lt24_pkg.sv
// Shared definitions for the LT24 (ILI9341) pixel writer: panel opcodes
// and the controller state encoding.
package lt24_pkg;

    // ILI9341 command and parameter opcodes used by the writer
    localparam logic [7:0] CMD_SLPOUT    = 8'h11;
    localparam logic [7:0] CMD_COLMOD    = 8'h3A;
    localparam logic [7:0] COLMOD_RGB565 = 8'h55;
    localparam logic [7:0] CMD_DISPON    = 8'h29;
    localparam logic [7:0] CMD_CASET     = 8'h2A;
    localparam logic [7:0] CMD_PASET     = 8'h2B;
    localparam logic [7:0] CMD_RAMWR     = 8'h2C;

    // Controller states: power-up sequence, then the pixel loop
    typedef enum logic [2:0] {
        RST_LOW,
        RST_WAIT,
        SLPOUT,
        SLP_WAIT,
        INIT,
        IDLE,
        ADDR_SEQ,
        DATA_WR
    } lt24_state_t;

endpackage

// File: rtl/lt24_bus_cycle.sv
// One 8080-style bus write: Wr_n low for WR_LOW cycles, then high for
// WR_HIGH cycles, with CS_n, RS and Data held for the whole write. A new
// start accepted in the last high cycle chains the next write with no gap,
// so CS_n stays low across a whole sequence of writes.
module lt24_bus_cycle #(
    parameter int WR_LOW  = 2,
    parameter int WR_HIGH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        start_rs,
    input  logic [15:0] start_data,
    output logic        ready,
    output logic        done,
    output logic        wr_n,
    output logic        cs_n,
    output logic        rs,
    output logic [15:0] data
);

    localparam int TOTAL = WR_LOW + WR_HIGH;
    localparam int IDX_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    logic             busy_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             wr_n_reg;
    logic             cs_n_reg;
    logic             rs_reg;
    logic [15:0]      data_reg;

    // Last cycle of the high phase: the write is complete after this edge
    assign done  = busy_reg && (idx_reg == IDX_W'(TOTAL - 1));
    // A new write may start when idle or when the current one is finishing
    assign ready = !busy_reg || done;

    assign wr_n = wr_n_reg;
    assign cs_n = cs_n_reg;
    assign rs   = rs_reg;
    assign data = data_reg;

    // Phase timer and registered panel strobes
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg <= 1'b0;
            idx_reg  <= '0;
            wr_n_reg <= 1'b1;
            cs_n_reg <= 1'b1;
            rs_reg   <= 1'b1;
            data_reg <= 16'h0000;
        end else if (start && ready) begin
            busy_reg <= 1'b1;
            idx_reg  <= '0;
            wr_n_reg <= 1'b0;
            cs_n_reg <= 1'b0;
            rs_reg   <= start_rs;
            data_reg <= start_data;
        end else if (busy_reg) begin
            if (done) begin
                busy_reg <= 1'b0;
                wr_n_reg <= 1'b1;
                cs_n_reg <= 1'b1;
            end else begin
                idx_reg <= idx_reg + IDX_W'(1);
                // Next cycle index reaches WR_LOW: enter the high phase
                if (idx_reg >= IDX_W'(WR_LOW - 1)) begin
                    wr_n_reg <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lt24_pixel_writer.sv
// LT24 pixel writer: accepts pixels on a ready/write handshake and turns
// them into ILI9341 bus writes, after a minimal power-up sequence.
// Raster-order pixels cost one data write; any other address first
// re-issues the column/page window and RAMWR.
// Optional build macro LT24_CLIP_EN: out-of-range coordinates are dropped
// without any bus activity and break the raster stream.
module lt24_pixel_writer
    import lt24_pkg::*;
#(
    parameter int WIDTH        = 240,
    parameter int HEIGHT       = 320,
    parameter int WR_LOW       = 2,
    parameter int WR_HIGH      = 2,
    parameter int RESET_CYCLES = 500000,
    parameter int WAIT_CYCLES  = 6000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  xAddr,
    input  logic [8:0]  yAddr,
    input  logic [15:0] pixelData,
    input  logic        pixelWrite,
    output logic        pixelReady,
    output logic        LT24Wr_n,
    output logic        LT24Rd_n,
    output logic        LT24CS_n,
    output logic        LT24RS,
    output logic        LT24Reset_n,
    output logic        LT24LCDOn,
    output logic [15:0] LT24Data
);

    lt24_state_t state_reg;
    logic [31:0] cnt_reg;
    logic [3:0]  step_reg;
    logic        issued_reg;
    logic        lcd_reset_n_reg;
    logic        lcd_on_reg;
    logic        pixel_ready_reg;
    logic        stream_valid_reg;
    logic [7:0]  x_reg;
    logic [8:0]  y_reg;
    logic [15:0] pix_reg;
    logic [7:0]  exp_x_reg;
    logic [8:0]  exp_y_reg;

    logic        bus_ready;
    logic        bus_done;
    logic        bus_start;
    logic        in_write_state;
    logic        seq_hit;
    logic        cur_rs;
    logic [15:0] cur_data;
    logic [3:0]  last_step;
    logic [15:0] x_word;
    logic [15:0] y_word;
    logic [15:0] w_word;
    logic [15:0] h_word;

    assign x_word = {8'h00, x_reg};
    assign y_word = {7'h00, y_reg};
    assign w_word = 16'(WIDTH - 1);
    assign h_word = 16'(HEIGHT - 1);

    // The incoming pixel continues the current raster stream
    assign seq_hit = stream_valid_reg && (xAddr == exp_x_reg) && (yAddr == exp_y_reg);

`ifdef LT24_CLIP_EN
    logic out_of_range;
    assign out_of_range = (32'(xAddr) >= 32'(WIDTH)) || (32'(yAddr) >= 32'(HEIGHT));
`endif

    // Issue the current step whenever the bus can take another write
    assign in_write_state = (state_reg inside {SLPOUT, INIT, ADDR_SEQ, DATA_WR});
    assign bus_start      = in_write_state && !issued_reg && bus_ready;

    // Word and RS for the current step of the active write sequence
    always_comb begin
        cur_rs    = 1'b0;
        cur_data  = 16'h0000;
        last_step = 4'd0;
        case (state_reg)
            SLPOUT: begin
                cur_data = {8'h00, CMD_SLPOUT};
            end
            INIT: begin
                last_step = 4'd2;
                case (step_reg)
                    4'd0:    cur_data = {8'h00, CMD_COLMOD};
                    4'd1: begin
                        cur_rs   = 1'b1;
                        cur_data = {8'h00, COLMOD_RGB565};
                    end
                    default: cur_data = {8'h00, CMD_DISPON};
                endcase
            end
            ADDR_SEQ: begin
                last_step = 4'd10;
                cur_rs    = 1'b1;
                case (step_reg)
                    4'd0: begin
                        cur_rs   = 1'b0;
                        cur_data = {8'h00, CMD_CASET};
                    end
                    4'd1:  cur_data = {8'h00, x_word[15:8]};
                    4'd2:  cur_data = {8'h00, x_word[7:0]};
                    4'd3:  cur_data = {8'h00, w_word[15:8]};
                    4'd4:  cur_data = {8'h00, w_word[7:0]};
                    4'd5: begin
                        cur_rs   = 1'b0;
                        cur_data = {8'h00, CMD_PASET};
                    end
                    4'd6:  cur_data = {8'h00, y_word[15:8]};
                    4'd7:  cur_data = {8'h00, y_word[7:0]};
                    4'd8:  cur_data = {8'h00, h_word[15:8]};
                    4'd9:  cur_data = {8'h00, h_word[7:0]};
                    default: begin
                        cur_rs   = 1'b0;
                        cur_data = {8'h00, CMD_RAMWR};
                    end
                endcase
            end
            DATA_WR: begin
                cur_rs   = 1'b1;
                cur_data = pix_reg;
            end
            default: ;
        endcase
    end

    lt24_bus_cycle #(
        .WR_LOW  (WR_LOW),
        .WR_HIGH (WR_HIGH)
    ) u_bus (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (bus_start),
        .start_rs   (cur_rs),
        .start_data (cur_data),
        .ready      (bus_ready),
        .done       (bus_done),
        .wr_n       (LT24Wr_n),
        .cs_n       (LT24CS_n),
        .rs         (LT24RS),
        .data       (LT24Data)
    );

    assign LT24Rd_n    = 1'b1;
    assign LT24Reset_n = lcd_reset_n_reg;
    assign LT24LCDOn   = lcd_on_reg;
    assign pixelReady  = pixel_ready_reg;

    // Main controller: power-up sequence, handshake and write sequencing
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= RST_LOW;
            cnt_reg          <= 32'd0;
            step_reg         <= 4'd0;
            issued_reg       <= 1'b0;
            lcd_reset_n_reg  <= 1'b0;
            lcd_on_reg       <= 1'b0;
            pixel_ready_reg  <= 1'b0;
            stream_valid_reg <= 1'b0;
            x_reg            <= 8'h00;
            y_reg            <= 9'h000;
            pix_reg          <= 16'h0000;
            exp_x_reg        <= 8'h00;
            exp_y_reg        <= 9'h000;
        end else begin
            lcd_on_reg <= 1'b1;
            case (state_reg)
                RST_LOW: begin
                    if (cnt_reg == 32'(RESET_CYCLES - 1)) begin
                        cnt_reg         <= 32'd0;
                        lcd_reset_n_reg <= 1'b1;
                        state_reg       <= RST_WAIT;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                RST_WAIT: begin
                    if (cnt_reg == 32'(WAIT_CYCLES - 1)) begin
                        cnt_reg   <= 32'd0;
                        state_reg <= SLPOUT;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                SLP_WAIT: begin
                    if (cnt_reg == 32'(WAIT_CYCLES - 1)) begin
                        cnt_reg   <= 32'd0;
                        state_reg <= INIT;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                SLPOUT, INIT, DATA_WR: begin
                    // Issue every step, then wait for the final write to end
                    if (bus_start) begin
                        if (step_reg == last_step) begin
                            issued_reg <= 1'b1;
                        end else begin
                            step_reg <= step_reg + 4'd1;
                        end
                        if (state_reg == DATA_WR) begin
                            stream_valid_reg <= 1'b1;
                            if (x_reg == 8'(WIDTH - 1)) begin
                                exp_x_reg <= 8'h00;
                                exp_y_reg <= (y_reg == 9'(HEIGHT - 1)) ? 9'h000 : y_reg + 9'd1;
                            end else begin
                                exp_x_reg <= x_reg + 8'd1;
                                exp_y_reg <= y_reg;
                            end
                        end
                    end else if (issued_reg && bus_done) begin
                        issued_reg <= 1'b0;
                        step_reg   <= 4'd0;
                        if (state_reg == SLPOUT) begin
                            cnt_reg   <= 32'd0;
                            state_reg <= SLP_WAIT;
                        end else begin
                            pixel_ready_reg <= 1'b1;
                            state_reg       <= IDLE;
                        end
                    end
                end
                ADDR_SEQ: begin
                    // Hand over to the data write as RAMWR is issued so it chains
                    if (bus_start) begin
                        if (step_reg == last_step) begin
                            step_reg  <= 4'd0;
                            state_reg <= DATA_WR;
                        end else begin
                            step_reg <= step_reg + 4'd1;
                        end
                    end
                end
                IDLE: begin
                    if (pixel_ready_reg && pixelWrite) begin
                        pixel_ready_reg <= 1'b0;
                        x_reg           <= xAddr;
                        y_reg           <= yAddr;
                        pix_reg         <= pixelData;
`ifdef LT24_CLIP_EN
                        if (out_of_range) begin
                            stream_valid_reg <= 1'b0;
                        end else if (seq_hit) begin
                            state_reg <= DATA_WR;
                        end else begin
                            state_reg <= ADDR_SEQ;
                        end
`else
                        if (seq_hit) begin
                            state_reg <= DATA_WR;
                        end else begin
                            state_reg <= ADDR_SEQ;
                        end
`endif
                    end else begin
                        pixel_ready_reg <= 1'b1;
                    end
                end
                default: state_reg <= RST_LOW;
            endcase
        end
    end

endmodule

// File: tb/tb_lt24_pixel_writer.sv
// Self-checking bench for lt24_pixel_writer. A pin monitor decodes every
// completed bus write and checks it against a queue filled by a behavioural
// model of the expected panel traffic; handshake latencies are compared
// against the same model.
module tb_lt24_pixel_writer;

    localparam int W  = 240;
    localparam int H  = 320;
    localparam int WL = 2;
    localparam int WH = 2;
    localparam int RC = 4;
    localparam int WC = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  xAddr = 8'h00;
    logic [8:0]  yAddr = 9'h000;
    logic [15:0] pixelData = 16'h0000;
    logic        pixelWrite = 1'b0;
    logic        pixelReady;
    logic        LT24Wr_n, LT24Rd_n, LT24CS_n, LT24RS, LT24Reset_n, LT24LCDOn;
    logic [15:0] LT24Data;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected bus writes, {rs, data}, in order
    logic [16:0] exp_q[$];
    // Model of the raster stream
    bit m_sv = 1'b0;
    int m_ex = 0;
    int m_ey = 0;

    logic [16:0] lit_00 [12];

    lt24_pixel_writer #(
        .WIDTH        (W),
        .HEIGHT       (H),
        .WR_LOW       (WL),
        .WR_HIGH      (WH),
        .RESET_CYCLES (RC),
        .WAIT_CYCLES  (WC)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .xAddr       (xAddr),
        .yAddr       (yAddr),
        .pixelData   (pixelData),
        .pixelWrite  (pixelWrite),
        .pixelReady  (pixelReady),
        .LT24Wr_n    (LT24Wr_n),
        .LT24Rd_n    (LT24Rd_n),
        .LT24CS_n    (LT24CS_n),
        .LT24RS      (LT24RS),
        .LT24Reset_n (LT24Reset_n),
        .LT24LCDOn   (LT24LCDOn),
        .LT24Data    (LT24Data)
    );

    always #5 clock = ~clock;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void push_cmd(input int c);
        exp_q.push_back({1'b0, 8'h00, 8'(c)});
    endfunction

    function automatic void push_par(input int v);
        exp_q.push_back({1'b1, 8'h00, 8'(v)});
    endfunction

    // Behavioural model of one accepted pixel: expected traffic and latency
    function automatic int model_pixel(input int x, input int y, input int d);
        int nw;
        int idx;
`ifdef LT24_CLIP_EN
        if (x >= W || y >= H) begin
            m_sv = 1'b0;
            return 1;
        end
`endif
        nw = 1;
        if (!(m_sv && x == m_ex && y == m_ey)) begin
            push_cmd(8'h2A);
            push_par(x / 256); push_par(x % 256);
            push_par((W - 1) / 256); push_par((W - 1) % 256);
            push_cmd(8'h2B);
            push_par(y / 256); push_par(y % 256);
            push_par((H - 1) / 256); push_par((H - 1) % 256);
            push_cmd(8'h2C);
            nw = 12;
        end
        exp_q.push_back({1'b1, 16'(d)});
        idx  = (y * W + x + 1) % (W * H);
        m_ex = idx % W;
        m_ey = idx / W;
        m_sv = 1'b1;
        return 1 + nw * (WL + WH);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one pixel and complete the accept edge; returns model latency
    task automatic do_pixel(input int x, input int y, input int d, output int lat);
        int n;
        n = 0;
        while (pixelReady !== 1'b1 && n < 1000) begin
            step();
            n++;
        end
        chk("ready_before_write", {31'd0, pixelReady}, 32'd1);
        lat        = model_pixel(x, y, d);
        xAddr      = x[7:0];
        yAddr      = y[8:0];
        pixelData  = d[15:0];
        pixelWrite = 1'b1;
        step();
        pixelWrite = 1'b0;
        xAddr      = 8'($urandom);
        yAddr      = 9'($urandom);
        pixelData  = 16'($urandom);
        $display("[TB] pixel (%0d,%0d) data=%04h expected latency %0d", x, y, d, lat);
    endtask

    // Count busy cycles while poking ignored requests with junk inputs
    task automatic wait_done(input int exp_lat, input string name);
        int n;
        n = 0;
        while (pixelReady === 1'b0 && n < 1000) begin
            n++;
            pixelWrite = 1'($urandom_range(0, 1));
            xAddr      = 8'($urandom);
            yAddr      = 9'($urandom);
            pixelData  = 16'($urandom);
            step();
        end
        pixelWrite = 1'b0;
        chk(name, n, exp_lat);
        chk("cs_idle_after_pixel", {31'd0, LT24CS_n}, 32'd1);
        chk("wr_idle_after_pixel", {31'd0, LT24Wr_n}, 32'd1);
    endtask

    // Release reset and check the power-up sequence
    task automatic init_seq();
        int n;
        push_cmd(8'h11);
        push_cmd(8'h3A);
        push_par(8'h55);
        push_cmd(8'h29);
        reset_n = 1'b1;
        n = 0;
        while (n < 100) begin
            step();
            n++;
            if (n == 1) chk("lcd_on_after_release", {31'd0, LT24LCDOn}, 32'd1);
            if (LT24Reset_n === 1'b1) break;
        end
        chk("panel_reset_cycles", n, RC);
        n = 0;
        while (pixelReady !== 1'b1 && n < 500) begin
            step();
            n++;
        end
        chk("init_ready", {31'd0, pixelReady}, 32'd1);
        chk("init_writes_done", exp_q.size(), 0);
        $display("[TB] init sequence complete after %0d cycles", n);
    endtask

    // Pin monitor: phase widths, stability, chip select and decoded writes
    logic        mon_prev_wr_n = 1'b1;
    logic        mon_hi_active = 1'b0;
    int          mon_low_cnt = 0;
    int          mon_high_cnt = 0;
    logic [16:0] mon_cap = '0;
    logic [16:0] mon_exp;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                mon_prev_wr_n = 1'b1;
                mon_hi_active = 1'b0;
                mon_low_cnt   = 0;
                mon_high_cnt  = 0;
            end else begin
                chk("rd_n_const", {31'd0, LT24Rd_n}, 32'd1);
                if (LT24Wr_n === 1'b0) begin
                    chk("cs_low_in_write", {31'd0, LT24CS_n}, 32'd0);
                    if (mon_prev_wr_n === 1'b1) begin
                        if (mon_hi_active) chk("high_phase_chained", mon_high_cnt, WH);
                        mon_hi_active = 1'b0;
                        mon_cap       = {LT24RS, LT24Data};
                        mon_low_cnt   = 1;
                    end else begin
                        mon_low_cnt++;
                        chk("stable_low", {15'd0, LT24RS, LT24Data}, {15'd0, mon_cap});
                    end
                end else begin
                    if (mon_prev_wr_n === 1'b0) begin
                        chk("low_phase", mon_low_cnt, WL);
                        chk("stable_rise", {15'd0, LT24RS, LT24Data}, {15'd0, mon_cap});
                        chk("cs_low_rise", {31'd0, LT24CS_n}, 32'd0);
                        if (exp_q.size() == 0) begin
                            n_tests++;
                            n_fail++;
                            $display("FAIL unexpected_write: got rs=%0d data=0x%04h, expected no write", LT24RS, LT24Data);
                        end else begin
                            mon_exp = exp_q.pop_front();
                            chk("bus_write", {15'd0, LT24RS, LT24Data}, {15'd0, mon_exp});
                        end
                        mon_hi_active = 1'b1;
                        mon_high_cnt  = 1;
                    end else if (mon_hi_active) begin
                        if (LT24CS_n === 1'b1) begin
                            chk("high_phase_last", mon_high_cnt, WH);
                            mon_hi_active = 1'b0;
                        end else begin
                            mon_high_cnt++;
                            chk("stable_high", {15'd0, LT24RS, LT24Data}, {15'd0, mon_cap});
                        end
                    end else begin
                        chk("cs_idle", {31'd0, LT24CS_n}, 32'd1);
                    end
                end
                mon_prev_wr_n = LT24Wr_n;
            end
        end
    end

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int x;
        int y;

        lit_00 = '{17'h0002A, 17'h10000, 17'h10000, 17'h10000, 17'h100EF,
                   17'h0002B, 17'h10000, 17'h10000, 17'h10001, 17'h1003F,
                   17'h0002C, 17'h1F800};

        // Reset state
        reset_n = 1'b0;
        repeat (3) step();
        chk("rst_pixelReady", {31'd0, pixelReady}, 32'd0);
        chk("rst_wr_n", {31'd0, LT24Wr_n}, 32'd1);
        chk("rst_rd_n", {31'd0, LT24Rd_n}, 32'd1);
        chk("rst_cs_n", {31'd0, LT24CS_n}, 32'd1);
        chk("rst_rs", {31'd0, LT24RS}, 32'd1);
        chk("rst_panel_reset", {31'd0, LT24Reset_n}, 32'd0);
        chk("rst_lcd_on", {31'd0, LT24LCDOn}, 32'd0);
        chk("rst_data", {16'd0, LT24Data}, 32'd0);

        init_seq();

        // First pixel: full window sequence; pin the model against literals
        do_pixel(0, 0, 16'hF800, lat);
        chk("model_lat_nonseq", lat, 49);
        for (int i = 0; i < 12; i++) chk("model_seq_00", {15'd0, exp_q[i]}, {15'd0, lit_00[i]});
        wait_done(lat, "latency_0_0");

        // Raster continuation
        do_pixel(1, 0, 16'h07E0, lat);
        chk("model_lat_seq", lat, 5);
        wait_done(lat, "latency_1_0");
        do_pixel(2, 0, 16'h001F, lat);
        wait_done(5, "latency_2_0");

        // Row wrap, then a jump
        do_pixel(239, 5, 16'h1234, lat);
        wait_done(lat, "latency_239_5");
        do_pixel(0, 6, 16'h5678, lat);
        chk("model_lat_rowwrap", lat, 5);
        wait_done(lat, "latency_0_6");
        do_pixel(10, 10, 16'h9ABC, lat);
        chk("model_x_lo_10", {15'd0, exp_q[2]}, 32'h1000A);
        chk("model_y_lo_10", {15'd0, exp_q[7]}, 32'h1000A);
        wait_done(49, "latency_10_10");

        // Last pixel of the frame wraps to the origin
        do_pixel(239, 319, 16'hFFFF, lat);
        wait_done(lat, "latency_239_319");
        do_pixel(0, 0, 16'h0001, lat);
        wait_done(5, "latency_frame_wrap");

`ifdef LT24_CLIP_EN
        do_pixel(240, 0, 16'hAAAA, lat);
        chk("model_lat_clip", lat, 1);
        wait_done(lat, "latency_clip");
        do_pixel(5, 0, 16'h5555, lat);
        wait_done(49, "latency_after_clip");
`endif

        // Randomised stream: mostly raster continuation, some jumps
        for (int i = 0; i < 40; i++) begin
            if (m_sv && $urandom_range(0, 9) < 7) begin
                x = m_ex;
                y = m_ey;
            end else begin
                x = $urandom_range(0, W - 1);
                y = $urandom_range(0, H - 1);
            end
            do_pixel(x, y, $urandom_range(0, 65535), lat);
            wait_done(lat, "latency_random");
            repeat ($urandom_range(0, 3)) step();
        end

        // Reset during the page-address parameters
        do_pixel(100, 50, 16'hC0DE, lat);
        chk("model_lat_pre_reset", lat, 49);
        repeat (25) step();
        chk("midop_wr_low", {31'd0, LT24Wr_n}, 32'd0);
        chk("midop_param", {15'd0, LT24RS, LT24Data}, 32'h10000);
        reset_n = 1'b0;
        #1;
        chk("midrst_wr_n", {31'd0, LT24Wr_n}, 32'd1);
        chk("midrst_cs_n", {31'd0, LT24CS_n}, 32'd1);
        chk("midrst_panel_reset", {31'd0, LT24Reset_n}, 32'd0);
        chk("midrst_ready", {31'd0, pixelReady}, 32'd0);
        exp_q.delete();
        m_sv = 1'b0;
        repeat (3) step();
        init_seq();

        // Stream state is gone after reset: address sequence again
        do_pixel(101, 50, 16'hBEEF, lat);
        wait_done(49, "latency_after_reset");

        repeat (4) step();
        chk("all_writes_seen", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
